// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: payload + valid with bubble, flush and hold.
// Optional stall/bubble/flush counters built when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 32,
    parameter int                 STALL_W   = 6,
    parameter int                 STAGE     = 2,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic s_up;
    logic s_dn;
    logic bubble;
    logic unused_bits;

    assign s_up   = stall[STAGE];
    assign s_dn   = stall[STAGE+1];
    assign bubble = s_up && !s_dn;

    // Only two stall bits matter here; the rest of the vector is for other boundaries.
    assign unused_bits = ^{stall, cnt_clr};

    // Boundary register: reset/flush/bubble insert a NOP, load when upstream runs, else hold.
    always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
            out_valid <= 1'b0;
            out_data  <= NOP_VALUE;
        end else if (!s_up) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stall-cycle counter, saturating; flush cycles still count as stalled.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
        end else if (s_up && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Bubble counter, saturating; a flush takes precedence over a bubble.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!flush && bubble && bubble_cnt != CNT_MAX) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    // Flush counter, saturating.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            flush_cnt <= '0;
        end else if (flush && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

`else

    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, corner sequences, randomized run vs model.
// Counter expectations follow the PIPE_STAGE_PERF_CNT_EN build setting.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        rst0, flush0, clr0, iv0;
    logic [5:0]  st0;
    logic [31:0] id0;
    logic        ov0;
    logic [31:0] od0;
    logic [15:0] sc0, bc0, fc0;

    logic        rst1, flush1, clr1, iv1;
    logic [5:0]  st1;
    logic [31:0] id1;
    logic        ov1;
    logic [31:0] od1;
    logic [3:0]  sc1, bc1, fc1;

    pipe_stage_reg u0 (
        .clk(clk), .rst(rst0), .stall(st0), .flush(flush0),
        .in_valid(iv0), .in_data(id0),
        .out_valid(ov0), .out_data(od0), .cnt_clr(clr0),
        .stall_cnt(sc0), .bubble_cnt(bc0), .flush_cnt(fc0)
    );

    pipe_stage_reg #(
        .DATA_W(32), .STALL_W(6), .STAGE(0),
        .NOP_VALUE(32'h0000_0013), .CNT_W(4)
    ) u1 (
        .clk(clk), .rst(rst1), .stall(st1), .flush(flush1),
        .in_valid(iv1), .in_data(id1),
        .out_valid(ov1), .out_data(od1), .cnt_clr(clr1),
        .stall_cnt(sc1), .bubble_cnt(bc1), .flush_cnt(fc1)
    );

    typedef struct {
        bit          v;
        logic [31:0] d;
        int          sc;
        int          bc;
        int          fc;
    } mdl_t;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          clr;
        bit          iv;
        logic [5:0]  st;
        logic [31:0] id;
        bit          ev;
        logic [31:0] ed;
        int          sc;
        int          bc;
        int          fc;
    } vec_t;

    mdl_t m0, m1;
    vec_t tbl [16];
    int   tests = 0;
    int   fails = 0;

    function automatic int sat_inc(int c, int mx);
        return (c < mx) ? c + 1 : mx;
    endfunction

    // Reference: classify the cycle's event, then apply its effect.
    function automatic mdl_t mstep(mdl_t m, bit r, bit fl, bit clr, bit iv,
                                   logic [31:0] id, bit su, bit sd,
                                   logic [31:0] nop, int mx);
        mdl_t n;
        n = m;
        if (r || fl || (su && !sd)) begin
            n.v = 1'b0;
            n.d = nop;
        end else if (!su) begin
            n.v = iv;
            n.d = id;
        end
        if (r || clr) begin
            n.sc = 0;
            n.bc = 0;
            n.fc = 0;
        end else begin
            if (su) n.sc = sat_inc(m.sc, mx);
            if (fl) n.fc = sat_inc(m.fc, mx);
            else if (su && !sd) n.bc = sat_inc(m.bc, mx);
        end
        return n;
    endfunction

    function automatic logic [31:0] cexp(int c);
        return PERF ? 32'(c) : 32'd0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_model(string tag, mdl_t m, logic v, logic [31:0] d,
                             logic [31:0] sc, logic [31:0] bc, logic [31:0] fc);
        chk({tag, ".valid"}, 32'(v), 32'(m.v));
        chk({tag, ".data"}, d, m.d);
        chk({tag, ".stall_cnt"}, sc, cexp(m.sc));
        chk({tag, ".bubble_cnt"}, bc, cexp(m.bc));
        chk({tag, ".flush_cnt"}, fc, cexp(m.fc));
    endtask

    task automatic tick(bit use_m0);
        m0 = mstep(m0, rst0, flush0, clr0, iv0, id0, st0[2], st0[3],
                   32'h0, 65535);
        m1 = mstep(m1, rst1, flush1, clr1, iv1, id1, st1[0], st1[1],
                   32'h0000_0013, 15);
        @(posedge clk);
        #1;
        if (use_m0)
            cmp_model("u0", m0, ov0, od0, 32'(sc0), 32'(bc0), 32'(fc0));
        cmp_model("u1", m1, ov1, od1, 32'(sc1), 32'(bc1), 32'(fc1));
    endtask

    initial begin
        //          rst fl clr iv stall      in_data       ev out_data      sc bc fc
        tbl[0]  = '{1, 0, 0, 1, 6'b000000, 32'hDEADBEEF, 0, 32'h0,        0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 6'b000000, 32'hDEADBEEF, 0, 32'h0,        0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 6'b000000, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 6'b000000, 32'h11111111, 1, 32'h11111111, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 6'b001111, 32'h22222222, 1, 32'h11111111, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 6'b001111, 32'h22222222, 1, 32'h11111111, 2, 0, 0};
        tbl[6]  = '{0, 0, 0, 1, 6'b001111, 32'h22222222, 1, 32'h11111111, 3, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 6'b000000, 32'h22222222, 1, 32'h22222222, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 6'b000111, 32'h44444444, 0, 32'h0,        1, 1, 0};
        tbl[9]  = '{0, 0, 0, 1, 6'b000111, 32'h44444444, 0, 32'h0,        2, 2, 0};
        tbl[10] = '{0, 0, 0, 1, 6'b000000, 32'h44444444, 1, 32'h44444444, 2, 2, 0};
        tbl[11] = '{0, 0, 0, 1, 6'b000000, 32'h33333333, 1, 32'h33333333, 2, 2, 0};
        tbl[12] = '{0, 1, 0, 1, 6'b001111, 32'h55555555, 0, 32'h0,        3, 2, 1};
        tbl[13] = '{0, 1, 0, 1, 6'b000111, 32'h55555555, 0, 32'h0,        4, 2, 2};
        tbl[14] = '{0, 0, 0, 0, 6'b000000, 32'h66666666, 0, 32'h66666666, 4, 2, 2};
        tbl[15] = '{1, 1, 0, 1, 6'b001111, 32'h77777777, 0, 32'h0,        0, 0, 0};

        m0 = '{0, 32'h0, 0, 0, 0};
        m1 = '{0, 32'h0, 0, 0, 0};
        rst1 = 1'b1; flush1 = 1'b0; clr1 = 1'b0; iv1 = 1'b0;
        st1 = '0; id1 = '0;

        for (int i = 0; i < 16; i++) begin
            rst0   = tbl[i].rst;
            flush0 = tbl[i].flush;
            clr0   = tbl[i].clr;
            iv0    = tbl[i].iv;
            st0    = tbl[i].st;
            id0    = tbl[i].id;
            tick(1'b0);
            chk($sformatf("row%0d.valid", i), 32'(ov0), 32'(tbl[i].ev));
            chk($sformatf("row%0d.data", i), od0, tbl[i].ed);
            chk($sformatf("row%0d.stall_cnt", i), 32'(sc0), cexp(tbl[i].sc));
            chk($sformatf("row%0d.bubble_cnt", i), 32'(bc0), cexp(tbl[i].bc));
            chk($sformatf("row%0d.flush_cnt", i), 32'(fc0), cexp(tbl[i].fc));
        end

        rst0 = 1'b1; flush0 = 1'b0; clr0 = 1'b0; st0 = '0;

        rst1 = 1'b1;
        tick(1'b1);
        chk("u1.reset_nop", od1, 32'h0000_0013);
        rst1 = 1'b0; iv1 = 1'b1; id1 = 32'hAAAA0001; st1 = '0;
        tick(1'b1);
        chk("u1.load", od1, 32'hAAAA0001);
        st1 = 6'b000001;
        tick(1'b1);
        chk("u1.bubble_nop", od1, 32'h0000_0013);
        chk("u1.bubble_valid", 32'(ov1), 32'd0);
        tick(1'b1);
        chk("u1.bubble_cnt2", 32'(bc1), cexp(2));
        st1 = '0;
        tick(1'b1);
        chk("u1.reload", od1, 32'hAAAA0001);
        st1 = 6'b110011;
        id1 = 32'hBBBB0002;
        repeat (20) tick(1'b1);
        chk("u1.stall_sat", 32'(sc1), cexp(15));
        chk("u1.hold_data", od1, 32'hAAAA0001);
        clr1 = 1'b1;
        tick(1'b1);
        chk("u1.clr_stall", 32'(sc1), 32'd0);
        chk("u1.clr_bubble", 32'(bc1), 32'd0);
        clr1 = 1'b0;
        tick(1'b1);
        chk("u1.resume", 32'(sc1), cexp(1));

        rst0 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            rst0   = ($urandom_range(0, 31) == 0);
            flush0 = ($urandom_range(0, 7) == 0);
            clr0   = ($urandom_range(0, 15) == 0);
            iv0    = 1'($urandom);
            st0    = 6'($urandom);
            id0    = $urandom;
            rst1   = ($urandom_range(0, 31) == 0);
            flush1 = ($urandom_range(0, 7) == 0);
            clr1   = ($urandom_range(0, 31) == 0);
            iv1    = 1'($urandom);
            st1    = 6'($urandom);
            id1    = $urandom;
            tick(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register for the five-stage core. Replaces the per-stage hand-written boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block carrying an opaque payload bus plus a valid bit. It adds correct bubble insertion, a synchronous flush and optional per-stage stall/bubble/flush performance counters. One instance sits between each pair of adjacent stages; the `STAGE` parameter selects which bits of the shared `stall` vector it obeys.

## Interface
Parameters:
- `DATA_W`, 32: payload width in bits; ≥1.
- `STALL_W`, 6: width of the shared stall vector.
- `STAGE`, 2: index of this boundary's upstream stall bit; legal range 0..`STALL_W`-2. 2 = ID/EX.
- `NOP_VALUE`, {`DATA_W`{1'b0}}: payload driven on reset, bubble and flush.
- `CNT_W`, 16: width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
- `stall`  in  `STALL_W`  shared pipeline stall vector from the stall controller.
- `flush`  in  1  kill the content of this boundary.
- `in_valid`  in  1  upstream stage holds a real instruction.
- `in_data`  in  `DATA_W`  upstream payload.
- `out_valid`  out  1  registered valid to the downstream stage.
- `out_data`  out  `DATA_W`  registered payload to the downstream stage.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `stall_cnt`  out  `CNT_W`  cycles in which `stall[STAGE]` = 1.
- `bubble_cnt`  out  `CNT_W`  bubbles inserted.
- `flush_cnt`  out  `CNT_W`  flushes taken.

## Operation
Let `s_up` = `stall[STAGE]` and `s_dn` = `stall[STAGE+1]`. The register update is evaluated each rising edge. The first matching row wins:
1. `rst`: `out_valid` ← 0, `out_data` ← `NOP_VALUE`.
2. `flush`: `out_valid` ← 0, `out_data` ← `NOP_VALUE`. Flush overrides any stall.
3. Bubble (`s_up` = 1 and `s_dn` = 0): `out_valid` ← 0, `out_data` ← `NOP_VALUE`. The downstream stage proceeds with a NOP while upstream is held.
4. Load (`s_up` = 0): `out_valid` ← `in_valid`, `out_data` ← `in_data`.
5. Hold (`s_up` = 1 and `s_dn` = 1): outputs unchanged.

Effective states: EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
- Load moves to FULL if `in_valid` = 1, else to EMPTY.
- Bubble and flush move to EMPTY.
- Hold keeps the current state.

Counters (only with the macro; see Configuration):
- All counters are cleared by `rst` or `cnt_clr`; clear has priority over increment.
- `stall_cnt` +1 every cycle with `s_up` = 1, including flush cycles.
- `bubble_cnt` +1 on each row-3 cycle. Not counted when `flush` = 1.
- `flush_cnt` +1 on each row-2 cycle.
- Each counter saturates at all-ones and does not wrap.
- `rst` and `cnt_clr` cycles do not count.

## Timing
- Latency: one cycle from `in_*` to `out_*` on a load.
- No combinational path from any input to any output.
- Reset values: `out_valid` 0, `out_data` `NOP_VALUE`, all counters 0. Valid from the first edge with `rst` = 1.
- `rst` asserted mid-stall or mid-flush: reset values on that edge. The stall state is discarded.
- `stall` bits above `STAGE+1` and below `STAGE` are ignored.
- Counter outputs are registered and reflect events up to the previous edge.

## Configuration
Macro: `PIPE_STAGE_PERF_CNT_EN`.
- Defined: the three counters and the `cnt_clr` logic are built as specified.
- Undefined: no counter flops are synthesised. `stall_cnt`, `bubble_cnt` and `flush_cnt` are tied to 0, and `cnt_clr` is ignored. Port list is identical in both builds.
- Register/valid behaviour is identical in both builds.

## Test plan
Defaults unless noted: `DATA_W` 32, `STALL_W` 6, `STAGE` 2; macro defined.
- Reset: `rst`=1 for 2 cycles with `in_data`=32'hDEADBEEF, `in_valid`=1 → `out_valid`=0, `out_data`=0, all counters 0; first edge after release loads 32'hDEADBEEF, `out_valid`=1.
- Load/hold: load 32'h11111111; then `stall`=6'b001111 for 3 cycles while `in_data`=32'h22222222 → `out_data` stays 32'h11111111, `out_valid`=1; `stall_cnt`=3, `bubble_cnt`=0.
- Bubble: `stall`=6'b000111 for 2 cycles → `out_valid`=0, `out_data`=0 both cycles; `bubble_cnt`=2, `stall_cnt`=2; with `stall`=0 the next edge loads the held upstream value.
- Flush priority: `flush`=1 with `stall`=6'b001111, `out_data` previously 32'h33333333 → `out_valid`=0, `out_data`=0; `flush_cnt`=1, `stall_cnt`+1, `bubble_cnt` unchanged.
- Saturation/clear (`CNT_W`=4): `stall`=6'b001111 for 20 cycles → `stall_cnt`=4'hF; assert `cnt_clr` one cycle during the stall → all counters 0 next cycle, then resume counting.
- Macro off, `STAGE`=0, `NOP_VALUE`=32'h00000013: rerun the bubble scenario with `stall`=6'b000001 → `out_data`=32'h00000013, `out_valid`=0; all counters read 0 throughout.
